// File: rtl/sponge_arb_if.sv
// Bundle between the samplers, the sponge arbiter and the shared SHAKE sponge.
// The slave modport is the arbiter's view; the master modport is the requester/sponge side.
interface sponge_arb_if #(
  parameter int NUM_REQ       = 3,
  parameter int DATA_IN_BITS  = 64,
  parameter int DATA_OUT_BITS = 64
);
  localparam int LW = $clog2(DATA_IN_BITS) + 1;

  logic [NUM_REQ-1:0]              req, gnt, wdog_err;
  logic [NUM_REQ*DATA_IN_BITS-1:0] r_data_in;
  logic [NUM_REQ-1:0]              r_in_valid, r_in_last, r_out_ready;
  logic [NUM_REQ*LW-1:0]           r_last_len;
  logic [NUM_REQ-1:0]              r_in_ready, r_out_valid;
  logic [DATA_OUT_BITS-1:0]        r_data_out;

  logic                     sp_clear, sp_in_valid, sp_in_last, sp_out_ready;
  logic [DATA_IN_BITS-1:0]  sp_data_in;
  logic [LW-1:0]            sp_last_len;
  logic [DATA_OUT_BITS-1:0] sp_data_out;
  logic                     sp_in_ready, sp_out_valid;

  modport slave (
    input  req, r_data_in, r_in_valid, r_in_last, r_last_len, r_out_ready,
           sp_data_out, sp_in_ready, sp_out_valid,
    output gnt, wdog_err, r_in_ready, r_out_valid, r_data_out,
           sp_clear, sp_data_in, sp_in_valid, sp_in_last, sp_last_len, sp_out_ready
  );

  modport master (
    output req, r_data_in, r_in_valid, r_in_last, r_last_len, r_out_ready,
           sp_data_out, sp_in_ready, sp_out_valid,
    input  gnt, wdog_err, r_in_ready, r_out_valid, r_data_out,
           sp_clear, sp_data_in, sp_in_valid, sp_in_last, sp_last_len, sp_out_ready
  );
endinterface

// File: rtl/sponge_arbiter.sv
// Round-robin session arbiter sharing one SHAKE sponge between NUM_REQ samplers; clears the sponge
// before every session. Optional idle watchdog enabled by defining SPONGE_ARB_WATCHDOG_EN.
module sponge_arbiter #(
  parameter int NUM_REQ       = 3,
  parameter int DATA_IN_BITS  = 64,
  parameter int DATA_OUT_BITS = 64,
  parameter int WDOG_CYCLES   = 4096
) (
  input logic         clk,
  input logic         rst,
  sponge_arb_if.slave bus
);
  localparam int LW = $clog2(DATA_IN_BITS) + 1;
  localparam int OW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, CLEAR, BUSY} state_t;

  state_t          state, state_nxt;
  logic [OW-1:0]   owner, rr_ptr, win, owner_inc;
  logic            found, clr_q, busy, active, own_req, revoke;
  logic [NUM_REQ-1:0] cand;

  assign busy      = (state == BUSY);
  assign own_req   = bus.req[owner];
  assign active    = busy & own_req;
  assign owner_inc = (owner == OW'(NUM_REQ-1)) ? '0 : owner + 1'b1;

`ifdef SPONGE_ARB_WATCHDOG_EN
  localparam int CW = ($clog2(WDOG_CYCLES+1) > 12) ? $clog2(WDOG_CYCLES+1) : 12;

  logic [CW-1:0]      wcnt;
  logic [NUM_REQ-1:0] blocked, wdog_q;
  logic               hs;

  assign hs     = (bus.sp_in_valid & bus.sp_in_ready) | (bus.sp_out_valid & bus.sp_out_ready);
  assign revoke = active & ~hs & (wcnt == CW'(WDOG_CYCLES-1));
  // A revoked requester stays out of arbitration until it has dropped req once.
  assign cand   = bus.req & ~blocked;
  assign bus.wdog_err = wdog_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wcnt    <= '0;
      blocked <= '0;
      wdog_q  <= '0;
    end else begin
      wdog_q  <= '0;
      blocked <= blocked & bus.req;
      if (!busy || hs) wcnt <= '0;
      else             wcnt <= wcnt + 1'b1;
      if (revoke) begin
        wdog_q[owner]  <= 1'b1;
        blocked[owner] <= bus.req[owner];
      end
    end
  end
`else
  logic [31:0] wdog_unused;
  assign wdog_unused  = 32'(WDOG_CYCLES);
  assign revoke       = 1'b0;
  assign cand         = bus.req;
  assign bus.wdog_err = '0;
`endif

  // First candidate at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx   = 0;
    win   = rr_ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && cand[idx]) begin
        win   = OW'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = CLEAR;
      CLEAR:   state_nxt = BUSY;
      BUSY:    if (!own_req || revoke) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
      clr_q  <= 1'b1;
    end else begin
      state <= state_nxt;
      clr_q <= 1'b0;
      if (state == IDLE && found) owner <= win;
      if (busy && state_nxt == IDLE) rr_ptr <= owner_inc;
    end
  end

  assign bus.r_data_out = bus.sp_data_out;

  // Sponge-side data is forced to zero outside an active session.
  always_comb begin
    bus.gnt          = '0;
    bus.r_in_ready   = '0;
    bus.r_out_valid  = '0;
    bus.sp_data_in   = '0;
    bus.sp_in_valid  = 1'b0;
    bus.sp_in_last   = 1'b0;
    bus.sp_last_len  = '0;
    bus.sp_out_ready = 1'b0;
    bus.sp_clear     = ~rst | clr_q | (state == CLEAR);
    if (busy) begin
      bus.gnt[owner]         = 1'b1;
      bus.r_in_ready[owner]  = bus.sp_in_ready;
      bus.r_out_valid[owner] = bus.sp_out_valid;
    end
    if (active) begin
      bus.sp_data_in   = bus.r_data_in[int'(owner)*DATA_IN_BITS +: DATA_IN_BITS];
      bus.sp_in_valid  = bus.r_in_valid[owner];
      bus.sp_in_last   = bus.r_in_last[owner];
      bus.sp_last_len  = bus.r_last_len[int'(owner)*LW +: LW];
      bus.sp_out_ready = bus.r_out_ready[owner];
    end
  end
endmodule
